// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared SAT-engine constants: clause index width, UCS FSM encoding, control-word bits
package sat_pkg;

    localparam int CLAUSE_IDX_W = 10;

    localparam logic [1:0] UCS_IDLE  = 2'd0;
    localparam logic [1:0] UCS_SCALE = 2'd1;
    localparam logic [1:0] UCS_FETCH = 2'd2;

    localparam int UCS_REQUEST_BIT = 0;
    localparam int FIFO_RD_EN_BIT  = 1;
    localparam int FIFO_WR_EN_BIT  = 2;

    // Right-shift Galois feedback masks of maximal-length polynomials.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/ucs_lfsr.sv
// rtl/ucs_lfsr.sv - free-running Galois LFSR for WalkSAT picks; optional seed load under UCS_SEED_LOAD_EN
module ucs_lfsr
    import sat_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef UCS_SEED_LOAD_EN
    input  logic              seed_load_i,
    input  logic [LFSR_W-1:0] seed_i,
`endif
    output logic [LFSR_W-1:0] lfsr_o
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] step;

    always_comb begin
        step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end

`ifdef UCS_SEED_LOAD_EN
    // A zero seed would lock the register, so it falls back to the reset seed.
    always_comb begin
        lfsr_d = step;
        if (seed_load_i) begin
            lfsr_d = (seed_i == '0) ? LFSR_SEED : seed_i;
        end
    end
`else
    always_comb begin
        lfsr_d = step;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/unsat_clause_selector.sv
// rtl/unsat_clause_selector.sv - unsat-clause FIFO with head pop or random WalkSAT pick; UCS_SEED_LOAD_EN adds seed load
module unsat_clause_selector
    import sat_pkg::*;
#(
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
    parameter int                CLAUSE_IDX_W = sat_pkg::CLAUSE_IDX_W,
    parameter int                DEPTH        = 64,
    parameter int                PTR_W        = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    wr_en_i,
    input  logic [CLAUSE_IDX_W-1:0] wr_clause_i,
    input  logic                    rd_en_i,
    input  logic                    ucs_request_i,
`ifdef UCS_SEED_LOAD_EN
    input  logic                    seed_load_i,
    input  logic [LFSR_W-1:0]       seed_i,
`endif
    output logic                    sel_valid_o,
    output logic [CLAUSE_IDX_W-1:0] sel_clause_o,
    output logic                    all_sat_o,
    output logic [PTR_W:0]          count_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic                    overflow_o
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam int               PROD_W   = LFSR_W + PTR_W + 1;

    logic [CLAUSE_IDX_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d, addr_q, addr_d;
    logic [PTR_W:0]          count_q, count_d, cap_q, cap_d;
    logic [1:0]              state_q, state_d;
    logic                    ovf_q, ovf_d, valid_q, valid_d, allsat_q, allsat_d;
    logic [CLAUSE_IDX_W-1:0] sel_q, sel_d;
    logic [LFSR_W-1:0]       lfsr;
    logic [PROD_W-1:0]       prod;
    logic [PTR_W-1:0]        off;
    logic                    do_pop, do_push;

    ucs_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef UCS_SEED_LOAD_EN
        .seed_load_i (seed_load_i),
        .seed_i      (seed_i),
`endif
        .lfsr_o      (lfsr)
    );

    // Scaling the LFSR by the captured count keeps the offset inside the live entries.
    always_comb begin
        prod = PROD_W'(lfsr) * PROD_W'(cap_q);
        off  = PTR_W'(prod >> LFSR_W);
    end

    assign do_pop  = rd_en_i && (count_q != '0);
    assign do_push = wr_en_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        state_d  = state_q;
        cap_d    = cap_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        valid_d  = 1'b0;
        allsat_d = 1'b0;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = UCS_IDLE;
        end else begin
            if (do_push) begin
                tail_d = tail_q + PTR_ONE;
            end else if (wr_en_i) begin
                ovf_d = 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_ONE;
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_ONE;
            end
            if (rd_en_i) begin
                valid_d  = 1'b1;
                allsat_d = !do_pop;
                sel_d    = do_pop ? mem_q[head_q] : '0;
            end
            // A pick completing in FETCH owns the result port over a same-cycle pop.
            case (state_q)
                UCS_IDLE: begin
                    if (ucs_request_i && !rd_en_i) begin
                        if (count_q == '0) begin
                            valid_d  = 1'b1;
                            allsat_d = 1'b1;
                            sel_d    = '0;
                        end else begin
                            cap_d   = count_q;
                            state_d = UCS_SCALE;
                        end
                    end
                end
                UCS_SCALE: begin
                    addr_d  = head_q + off;
                    state_d = UCS_FETCH;
                end
                UCS_FETCH: begin
                    sel_d    = mem_q[addr_q];
                    valid_d  = 1'b1;
                    allsat_d = 1'b0;
                    state_d  = UCS_IDLE;
                end
                default: state_d = UCS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear_i && do_push) begin
            mem_q[tail_q] <= wr_clause_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            state_q  <= UCS_IDLE;
            cap_q    <= '0;
            addr_q   <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
            allsat_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            cap_q    <= cap_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            valid_q  <= valid_d;
            allsat_q <= allsat_d;
        end
    end

    assign sel_valid_o  = valid_q;
    assign sel_clause_o = sel_q;
    assign all_sat_o    = allsat_q;
    assign count_o      = count_q;
    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == FULL_CNT);
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_unsat_clause_selector.sv
// tb/tb_unsat_clause_selector.sv - directed and randomized checks of unsat_clause_selector against a queue model
module tb_unsat_clause_selector;

    localparam int          CW    = 10;
    localparam int          DEPTH = 64;
    localparam int          PTR_W = 6;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear_i = 1'b0;
    logic          wr_en_i = 1'b0;
    logic [CW-1:0] wr_clause_i = '0;
    logic          rd_en_i = 1'b0;
    logic          ucs_request_i = 1'b0;
`ifdef UCS_SEED_LOAD_EN
    logic          seed_load_i = 1'b0;
    logic [15:0]   seed_i = '0;
`endif
    logic          sel_valid_o;
    logic [CW-1:0] sel_clause_o;
    logic          all_sat_o;
    logic [PTR_W:0] count_o;
    logic          empty_o, full_o, overflow_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unsat_clause_selector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (clear_i),
        .wr_en_i       (wr_en_i),
        .wr_clause_i   (wr_clause_i),
        .rd_en_i       (rd_en_i),
        .ucs_request_i (ucs_request_i),
`ifdef UCS_SEED_LOAD_EN
        .seed_load_i   (seed_load_i),
        .seed_i        (seed_i),
`endif
        .sel_valid_o   (sel_valid_o),
        .sel_clause_o  (sel_clause_o),
        .all_sat_o     (all_sat_o),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .overflow_o    (overflow_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // LFSR as polynomial division by x over GF(2): x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [16:0] poly;
        logic [16:0] t;
        poly = 17'b1_0110_1000_0000_0001;
        t = {1'b0, s};
        if (t[0]) t = t ^ poly;
        return t[16:1];
    endfunction

    int          mq[$];
    logic [15:0] m_lfsr;
    int          m_stage = 0;
    int          m_cap, m_off;
    logic        m_valid = 1'b0, m_all = 1'b0, m_ovf = 1'b0;
    logic [CW-1:0] m_sel = '0;

    always @(posedge clk) begin : model
        logic [15:0] cur;
        int          st;
        bit          popped;
        cur = m_lfsr;
        st  = m_stage;
        if (!rst_n) begin
            mq.delete();
            m_lfsr  = SEED;
            m_stage = 0;
            m_valid = 1'b0;
            m_all   = 1'b0;
            m_sel   = '0;
            m_ovf   = 1'b0;
        end else begin
            m_lfsr = model_step(cur);
`ifdef UCS_SEED_LOAD_EN
            if (seed_load_i) m_lfsr = (seed_i == 16'h0) ? SEED : seed_i;
`endif
            m_valid = 1'b0;
            m_all   = 1'b0;
            if (clear_i) begin
                mq.delete();
                m_ovf   = 1'b0;
                m_stage = 0;
            end else begin
                popped = 1'b0;
                if (rd_en_i) begin
                    m_valid = 1'b1;
                    if (mq.size() > 0) begin
                        m_sel  = CW'(mq[0]);
                        popped = 1'b1;
                    end else begin
                        m_sel = '0;
                        m_all = 1'b1;
                    end
                end
                if (st == 2) begin
                    m_sel   = CW'(mq[m_off]);
                    m_valid = 1'b1;
                    m_all   = 1'b0;
                    m_stage = 0;
                end else if (st == 1) begin
                    m_off   = (int'(cur) * m_cap) >> 16;
                    m_stage = 2;
                end else if (ucs_request_i && !rd_en_i) begin
                    if (mq.size() == 0) begin
                        m_valid = 1'b1;
                        m_all   = 1'b1;
                        m_sel   = '0;
                    end else begin
                        m_cap   = mq.size();
                        m_stage = 1;
                    end
                end
                if (popped) void'(mq.pop_front());
                if (wr_en_i) begin
                    if (mq.size() < DEPTH) mq.push_back(int'(wr_clause_i));
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", 32'(sel_valid_o), 32'(m_valid));
        if (m_valid) chk("all_sat", 32'(all_sat_o), 32'(m_all));
        chk("sel_clause", 32'(sel_clause_o), 32'(m_sel));
        chk("count", 32'(count_o), mq.size());
        chk("empty", 32'(empty_o), 32'(mq.size() == 0));
        chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        wr_en_i = 1'b1;
        wr_clause_i = CW'(v);
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic pop_expect(input string name, input int v, input logic all);
        rd_en_i = 1'b1;
        tick();
        rd_en_i = 1'b0;
        chk({name, "_valid"}, 32'(sel_valid_o), 32'd1);
        chk({name, "_value"}, 32'(sel_clause_o), v);
        chk({name, "_all_sat"}, 32'(all_sat_o), 32'(all));
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    task automatic request_wait(output logic [CW-1:0] v, output bit got);
        ucs_request_i = 1'b1;
        tick();
        ucs_request_i = 1'b0;
        got = 1'b0;
        v = '0;
        for (int k = 0; k < 6; k++) begin
            if (sel_valid_o) begin
                got = 1'b1;
                v = sel_clause_o;
                break;
            end
            tick();
        end
        if (!got) chk("pick_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [CW-1:0] v;
        bit got, seen5, seen6;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_valid", 32'(sel_valid_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        rst_n = 1'b1;
        tick();

        push(3); push(7); push(9);
        pop_expect("pop1", 3, 1'b0);
        pop_expect("pop2", 7, 1'b0);
        pop_expect("pop3", 9, 1'b0);
        chk("pop_count", 32'(count_o), 32'd0);
        pop_expect("pop_empty", 0, 1'b1);

        for (int i = 0; i < 64; i++) push(i);
        push(100);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_overflow", 32'(overflow_o), 32'd1);
        chk("fill_count", 32'(count_o), 32'd64);
        wr_en_i = 1'b1;
        wr_clause_i = CW'(200);
        pop_expect("full_pushpop", 0, 1'b0);
        wr_en_i = 1'b0;
        chk("full_pushpop_count", 32'(count_o), 32'd64);
        pulse_clear();
        chk("clear_count", 32'(count_o), 32'd0);
        chk("clear_overflow", 32'(overflow_o), 32'd0);

        push(5); push(6);
        ucs_request_i = 1'b1;
        tick();
        ucs_request_i = 1'b0;
        chk("pick_lat1", 32'(sel_valid_o), 32'd0);
        tick();
        chk("pick_lat2", 32'(sel_valid_o), 32'd0);
        tick();
        chk("pick_lat3", 32'(sel_valid_o), 32'd1);
        chk("pick_in_set", 32'(sel_clause_o == 5 || sel_clause_o == 6), 32'd1);
        chk("pick_count", 32'(count_o), 32'd2);
        seen5 = 1'b0;
        seen6 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            request_wait(v, got);
            if (got && v == 5) seen5 = 1'b1;
            if (got && v == 6) seen6 = 1'b1;
        end
        chk("pick_seen5", 32'(seen5), 32'd1);
        chk("pick_seen6", 32'(seen6), 32'd1);

        pulse_clear();
        ucs_request_i = 1'b1;
        tick();
        ucs_request_i = 1'b0;
        chk("empty_req_valid", 32'(sel_valid_o), 32'd1);
        chk("empty_req_all_sat", 32'(all_sat_o), 32'd1);
        chk("empty_req_sel", 32'(sel_clause_o), 32'd0);

        for (int i = 0; i < 66; i++) push(i + 1);
        ucs_request_i = 1'b1;
        tick();
        ucs_request_i = 1'b0;
        pulse_clear();
        for (int k = 0; k < 3; k++) begin
            chk("clear_abort_valid", 32'(sel_valid_o), 32'd0);
            tick();
        end
        chk("clear_abort_count", 32'(count_o), 32'd0);
        chk("clear_abort_overflow", 32'(overflow_o), 32'd0);

        push(4);
        ucs_request_i = 1'b1;
        tick();
        ucs_request_i = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_abort_valid0", 32'(sel_valid_o), 32'd0);
        tick();
        chk("rst_abort_valid1", 32'(sel_valid_o), 32'd0);

`ifdef UCS_SEED_LOAD_EN
        begin
            logic [CW-1:0] picks [2][8];
            for (int p = 0; p < 2; p++) begin
                pulse_clear();
                for (int i = 0; i < 10; i++) push(10 + i);
                seed_load_i = 1'b1;
                seed_i = 16'h0001;
                tick();
                seed_load_i = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    request_wait(v, got);
                    picks[p][k] = v;
                end
            end
            for (int k = 0; k < 8; k++) chk("seed_repeat", 32'(picks[1][k]), 32'(picks[0][k]));
        end
`endif

        pulse_clear();
        for (int c = 0; c < 6000; c++) begin
            clear_i       = ($urandom_range(0, 299) == 0);
            wr_en_i       = ($urandom_range(0, 99) < 45);
            wr_clause_i   = CW'($urandom);
            rd_en_i       = (m_stage == 0) && ($urandom_range(0, 99) < ((c < 3000) ? 20 : 50));
            ucs_request_i = ($urandom_range(0, 99) < 25);
            tick();
        end
        clear_i = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        ucs_request_i = 1'b0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
